// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the arbiter top and its priority picker.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner search: first set request at or above ptr,
// wrapping modulo N. Purely combinational.
module rr_priority_pick
  import dram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [IW:0]    sum;
  logic           found;

  // rotate so ptr sits at bit 0, then take the lowest set bit
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    dbl     = {req_i, req_i} >> ptr_i;
    for (int j = 0; j < N; j++) begin
      if (!found && dbl[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IW+1)'(j);
        if (sum >= (IW+1)'(N)) begin
          sum = sum - (IW+1)'(N);
        end
        idx_o = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port
// between NUM_CORES cores; four cycles per transaction.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [$clog2(NUM_CORES)-1:0] grant_id,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IW = idx_w(NUM_CORES);

  state_e state_q, state_d;

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic                 wr_q, wr_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [ADDR_W-1:0]    maddr_q, maddr_d;
  logic [DATA_W-1:0]    mwdata_q, mwdata_d;
  logic                 mwe_q, mwe_d;

  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;

  logic [ADDR_W-1:0] addr_a  [NUM_CORES];
  logic [DATA_W-1:0] wdata_a [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_priority_pick #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: one cycle per state, leave IDLE only on a request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // output/datapath next values; the write strobe is a single pulse
  always_comb begin
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwe_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          sel_d    = pick_idx;
          wr_d     = we[pick_idx];
          maddr_d  = addr_a[pick_idx];
          mwdata_d = wdata_a[pick_idx];
          mwe_d    = we[pick_idx];
        end
      end
      ST_ACCESS: begin
        mwe_d = 1'b0;
      end
      ST_RESP: begin
        if (!wr_q) begin
          rdata_d = mem_rdata;
        end
        ack_d        = '0;
        ack_d[sel_q] = 1'b1;
        if (sel_q == IW'(NUM_CORES-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = sel_q + IW'(1);
        end
      end
      ST_DONE: begin
        ack_d = '0;
      end
      default: begin
        ack_d = '0;
      end
    endcase
  end

  // datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      sel_q    <= '0;
      wr_q     <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwe_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign grant_id  = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_we    = mwe_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level model plus directed
// scenarios on a 4-core instance and a 3-core instance.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- 4-core instance ----------------
  logic [3:0]  req = '0;
  logic [3:0]  a_we = '0;
  logic [11:0] a_addr [4];
  logic [31:0] a_wdata [4];
  logic [47:0] addr;
  logic [127:0] wdata;
  logic [3:0]  ack;
  logic [31:0] rdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;

  assign addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
  assign wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};

  dram_arbiter #(.NUM_CORES(4), .ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(a_we),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata),
    .grant_id(grant_id), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // synchronous memory: data for the address of cycle N appears in N+1
  logic [31:0] pmem [4096];
  always @(posedge clk) begin
    mem_rdata <= pmem[mem_addr];
    if (mem_we) pmem[mem_addr] = mem_wdata;
  end

  // ---------------- 3-core instance ----------------
  logic [2:0]  req3 = '0;
  logic [2:0]  we3 = '0;
  logic [35:0] addr3 = 36'h0030_0200_1;
  logic [95:0] wdata3 = '0;
  logic [2:0]  ack3;
  logic [31:0] rdata3;
  logic [1:0]  gid3;
  logic        busy3;
  logic [11:0] maddr3;
  logic [31:0] mwdata3;
  logic        mwe3;
  logic [31:0] mrdata3 = 32'h5A5A0000;

  dram_arbiter #(.NUM_CORES(3), .ADDR_W(12), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3),
    .addr(addr3), .wdata(wdata3), .ack(ack3), .rdata(rdata3),
    .grant_id(gid3), .busy(busy3), .mem_addr(maddr3),
    .mem_wdata(mwdata3), .mem_we(mwe3), .mem_rdata(mrdata3)
  );

  // ---------------- transaction-level model ----------------
  // m_age: cycles since the grant (0 = no transaction in flight)
  logic [31:0] mm [logic [11:0]];
  int          m_age = 0;
  int          m_ptr = 0;
  int          m_sel = 0;
  bit          m_wr = 0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] mread(input logic [11:0] a);
    return mm.exists(a) ? mm[a] : 32'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_ptr = 0; m_sel = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_age == 0) begin
      if (req != 0) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4;
            break;
          end
        end
        m_wr    = a_we[m_sel];
        m_addr  = a_addr[m_sel];
        m_wdata = a_wdata[m_sel];
        if (m_wr) mm[m_addr] = m_wdata;
        m_age = 1;
      end
    end else if (m_age == 2) begin
      if (!m_wr) m_rdata = mread(m_addr);
      m_ptr = (m_sel + 1) % 4;
      m_age = 3;
    end else if (m_age == 3) begin
      m_age = 0;
    end else begin
      m_age = m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("m_busy", busy, m_age != 0);
      chk("m_mem_we", mem_we, (m_age == 1) && m_wr);
      chk("m_mem_addr", mem_addr, m_addr);
      chk("m_mem_wdata", mem_wdata, m_wdata);
      chk("m_grant_id", grant_id, m_sel);
      chk("m_ack", ack, (m_age == 3) ? (64'd1 << m_sel) : 64'd0);
      chk("m_rdata", rdata, m_rdata);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nack;
    int last;
    int gap;
    for (int i = 0; i < 4; i++) begin
      a_addr[i] = '0;
      a_wdata[i] = '0;
    end
    for (int i = 0; i < 4096; i++) pmem[i] = '0;
    pmem[12'h0A5] = 32'hDEADBEEF;
    mm[12'h0A5]   = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      pmem[12'h100 + i] = 32'hA0000000 + i;
      mm[12'h100 + 12'(i)] = 32'hA0000000 + i;
    end
    pmem[12'h010] = 32'h00C0FFEE;
    mm[12'h010]   = 32'h00C0FFEE;

    // reset state
    @(negedge clk);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_mem_addr", mem_addr, 12'h0);
    #2 rst = 1'b0;
    chk_on = 1'b1;

    // all cores request: order 0,1,2,3 x4, four cycles apart
    go();
    for (int i = 0; i < 4; i++) a_addr[i] = 12'h100 + 12'(i);
    a_wdata[1] = 32'h11110001;
    a_we = 4'b0010;
    req = 4'b1111;
    nack = 0;
    last = 0;
    for (int c = 0; c < 100 && nack < 16; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        chk("fair_order", ack, 4'b0001 << (nack % 4));
        if (nack > 0) chk("fair_spacing", c - last, 4);
        last = c;
        nack++;
      end
    end
    chk("fair_count", nack, 16);
    go();
    req = '0;
    a_we = '0;

    // single read by core 2
    go();
    a_addr[2] = 12'h0A5;
    req = 4'b0100;
    negs(2);
    chk("rd_T1_addr", mem_addr, 12'h0A5);
    chk("rd_T1_we", mem_we, 1'b0);
    negs(2);
    chk("rd_T3_ack", ack, 4'b0100);
    chk("rd_T3_rdata", rdata, 32'hDEADBEEF);
    chk("rd_T3_grant", grant_id, 2'd2);
    go();
    req = '0;

    // single write by core 1
    go();
    a_addr[1] = 12'h3FF;
    a_wdata[1] = 32'h12345678;
    a_we = 4'b0010;
    req = 4'b0010;
    negs(2);
    chk("wr_T1_we", mem_we, 1'b1);
    chk("wr_T1_wdata", mem_wdata, 32'h12345678);
    negs(1);
    chk("wr_T2_we", mem_we, 1'b0);
    negs(1);
    chk("wr_T3_we", mem_we, 1'b0);
    chk("wr_T3_ack", ack, 4'b0010);
    chk("wr_T3_rdata", rdata, 32'hDEADBEEF);
    go();
    req = '0;
    a_we = '0;

    // late request from core 3 during core 0's ACCESS
    go();
    a_addr[0] = 12'h010;
    a_addr[3] = 12'h013;
    a_wdata[3] = 32'hCAFEF00D;
    a_we = 4'b1000;
    req = 4'b0001;
    negs(1);
    go();
    req = 4'b1001;
    negs(1);
    chk("late_T1_grant", grant_id, 2'd0);
    negs(2);
    chk("late_ack0", ack, 4'b0001);
    chk("late_rdata", rdata, 32'h00C0FFEE);
    go();
    req = 4'b1000;
    gap = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack != 0) begin
        gap = c;
        break;
      end
    end
    chk("late_gap", gap, 4);
    chk("late_ack3", ack, 4'b1000);
    chk("late_grant3", grant_id, 2'd3);
    go();
    req = '0;
    a_we = '0;

    // three cores: ptr=2 with cores 0,1 requesting, then wrap
    go();
    req3 = 3'b010;
    negs(4);
    chk("n3_first_ack", ack3, 3'b010);
    go();
    req3 = 3'b011;
    negs(2);
    chk("n3_skip_grant", gid3, 2'd0);
    chk("n3_skip_addr", maddr3, 12'h001);
    negs(2);
    chk("n3_ack0", ack3, 3'b001);
    go();
    req3 = 3'b010;
    negs(4);
    chk("n3_ack1", ack3, 3'b010);
    chk("n3_grant1", gid3, 2'd1);
    chk("n3_rdata", rdata3, 32'h5A5A0000);
    go();
    req3 = 3'b111;
    negs(4);
    chk("n3_ack2", ack3, 3'b100);
    go();
    req3 = 3'b011;
    negs(4);
    chk("n3_wrap_ack", ack3, 3'b001);
    go();
    req3 = '0;

    // reset in the ACCESS cycle of a write
    go();
    a_addr[1] = 12'h044;
    req = 4'b0010;
    negs(4);
    chk("rs_pre_ack", ack, 4'b0010);
    go();
    a_addr[1] = 12'h3FE;
    a_wdata[1] = 32'hBAD0BAD0;
    a_we = 4'b0010;
    negs(2);
    chk("rs_T1_we", mem_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rs_async_we", mem_we, 1'b0);
    chk("rs_async_ack", ack, 4'b0000);
    chk("rs_async_busy", busy, 1'b0);
    req = '0;
    a_we = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    go();
    a_addr[0] = 12'h0A5;
    a_addr[2] = 12'h102;
    req = 4'b0101;
    negs(2);
    chk("rs_prio_grant", grant_id, 2'd0);
    chk("rs_prio_addr", mem_addr, 12'h0A5);
    negs(2);
    chk("rs_prio_ack", ack, 4'b0001);
    chk("rs_prio_rdata", rdata, 32'hDEADBEEF);
    go();
    req = '0;
    negs(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter that shares the single data-memory port (address/data/write-enable) between `NUM_CORES` processor cores in the multi-core build. Each core presents its AR/DR/write-enable as a held request. The arbiter serialises the requests onto the memory port and returns a one-cycle acknowledge, plus read data, to the winning core. It sits between the core array and the data-memory block.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesting cores, 2..16, need not be a power of two.
- `ADDR_W`, 12: memory address width (matches AR).
- `DATA_W`, 32: memory data width (matches DR).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `NUM_CORES`: per-core request, held high until `ack`.
- `we` in `NUM_CORES`: per-core write flag, qualified by `req`.
- `addr` in `NUM_CORES*ADDR_W`: packed addresses; core i at bits [i*ADDR_W +: ADDR_W].
- `wdata` in `NUM_CORES*DATA_W`: packed write data, same packing.
- `ack` out `NUM_CORES`: one-hot, one-cycle completion pulse.
- `rdata` out `DATA_W`: read data for the acknowledged read.
- `grant_id` out clog2(`NUM_CORES`): index of the current or last granted core.
- `busy` out 1: high in every state except IDLE.
- `mem_addr` out `ADDR_W`: to data memory.
- `mem_wdata` out `DATA_W`: to data memory.
- `mem_we` out 1: memory write strobe.
- `mem_rdata` in `DATA_W`: from data memory. The memory is synchronous, with read data valid the cycle after the address is presented.

## Operation
- FSM has four states: IDLE → ACCESS → RESP → DONE → IDLE. Every transaction spends exactly one cycle in each state, reads and writes alike.
- **IDLE**
  - If `req` != 0, pick the winner: the first requesting core found searching upward from `ptr`, wrapping modulo `NUM_CORES`.
  - Register `sel`, `grant_id`, `mem_addr`, `mem_wdata` and `mem_we` <= `we[sel]`, then go to ACCESS.
  - If `req` == 0, stay in IDLE. All outputs hold, except `mem_we`, which is 0.
- **ACCESS**: memory sees the address and strobe this cycle. `mem_we` <= 0. Go to RESP.
- **RESP**
  - `mem_rdata` is valid this cycle.
  - For a read, register `rdata` <= `mem_rdata`. For a write, `rdata` holds.
  - `ack[sel]` <= 1. `ptr` <= (`sel`+1) mod `NUM_CORES`. Go to DONE.
- **DONE**: `ack[sel]` is high this cycle. `ack` <= 0. Go to IDLE.
- Core contract:
  - A core must drop `req` on the edge that ends its `ack` cycle, unless it wants a back-to-back transaction.
  - `addr`, `wdata` and `we` must stay stable while `req` is high.
  - Request and data inputs of the core in service are not resampled after IDLE. Changes after the grant are ignored.
- Fairness: a continuously requesting core waits at most `NUM_CORES`-1 other transactions.
- `rdata` stays stable from its update until the next read RESP.
- `mem_addr` and `mem_wdata` hold their last granted values between transactions.

## Timing
- Reset values: state IDLE, `ptr` 0, `sel` 0, `grant_id` 0, `ack` 0, `rdata` 0, `mem_addr` 0, `mem_wdata` 0, `mem_we` 0, `busy` 0.
- Reset is asynchronous. Asserting it mid-transaction immediately forces `mem_we` = 0 and `ack` = 0, and aborts the transaction. A write aborted during ACCESS may or may not have landed in memory.
- Latency: with `req` sampled at the edge ending cycle T0, the memory is driven in T1, data is captured at the end of T2, and `ack` is high in T3. Request-to-ack is 3 cycles.
- Throughput: one transaction per 4 cycles. A new grant can be sampled in T4.
- After reset, core 0 has the highest priority.
- If all cores request at once, grants go in the order 0, 1, 2, …, `NUM_CORES`-1, 0.
- A `req` that rises while the arbiter is busy is sampled at the next IDLE.
- `ptr` wraps from `NUM_CORES`-1 to 0, including for non-power-of-two counts.

## Structure
- Package `dram_arb_pkg`:
  - State enum (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`, `ST_DONE`).
  - Default `ADDR_W`/`DATA_W` constants.
  - A clog2-based index-width function.
- Sub-module `rr_priority_pick`: purely combinational. Takes `req` and `ptr`; outputs `valid` and the winning index.
- The top level holds the FSM, `ptr` and the output registers.

## Test plan
- Single read: core 2 reads addr 0x0A5 and memory returns 0xDEADBEEF. Expect `mem_addr`=0x0A5 and `mem_we`=0 in T1, `ack`=4'b0100 and `rdata`=0xDEADBEEF in T3, `grant_id`=2.
- Single write: core 1 writes 0x12345678 to 0x3FF. Expect `mem_we`=1 for exactly one cycle (T1) with `mem_wdata`=0x12345678, `ack[1]` in T3, and `rdata` unchanged.
- All-request fairness: all 4 cores hold `req` for 16 transactions. Expect grant order 0,1,2,3 repeated 4 times, with acks spaced exactly 4 cycles apart.
- Pointer wrap and skip: with `NUM_CORES`=3, `ptr`=2 and only cores 0 and 1 requesting, expect grants 0 then 1.
- Late request: core 3 raises `req` during core 0's ACCESS. Core 0 completes, then core 3 is granted in the next IDLE with no `ack` glitch.
- Reset mid-operation: assert `rst` during ACCESS of a write. `mem_we` and `ack` drop to 0 asynchronously. After release the state is IDLE and core 0 has priority.
